// File: rtl/bd_funnel_pkg.sv
// Shared BD funnel types and constants.
// Default chunk-count table and table-entry check.
package bd_funnel_pkg;

  localparam int BD_LEAF_W     = 5;
  localparam int BD_PAYLOAD_W  = 25;
  localparam int BD_MAX_SER    = 4;
  localparam int BD_NUM_LEAVES = 20;
  localparam int BD_CNT_W      = $clog2(BD_MAX_SER + 1);
  localparam int BD_TBL_W      = BD_NUM_LEAVES * BD_CNT_W;

  typedef struct packed {
    logic [BD_LEAF_W-1:0]    leaf_code;
    logic [BD_PAYLOAD_W-1:0] payload;
  } UnencodedBDWord;

  function automatic logic [BD_TBL_W-1:0] def_ser_table();
    logic [BD_TBL_W-1:0] t;
    t = '0;
    for (int l = 0; l < BD_NUM_LEAVES; l++) begin
      t[l*BD_CNT_W +: BD_CNT_W] = BD_CNT_W'((l % BD_MAX_SER) + 1);
    end
    return t;
  endfunction

  localparam logic [BD_TBL_W-1:0] BD_SER_TABLE = def_ser_table();

  // A table entry is usable when it names 1..max_ser chunks.
  function automatic logic cnt_ok(input int ent, input int max_ser);
    return (ent != 0) && (ent <= max_ser);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first
// requester after the last winner; pointer moves on advance.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  // Search starts one past the last winner, wrapping.
  always_comb begin
    int idx;
    logic found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr_q) + off) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Winner becomes the new pointer when the grant is used.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      for (int i = 0; i < N; i++) begin
        if (gnt_o[i]) ptr_d = PW'(i);
      end
    end
  end

  // Pointer register; channel 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bd_funnel_serializer_rr.sv
// N-input BD word funnel: round-robin pick, then
// split the payload into table-sized chunks, LS first.
module bd_funnel_serializer_rr
  import bd_funnel_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int LEAF_W     = BD_LEAF_W,
  parameter int PAYLOAD_W  = BD_PAYLOAD_W,
  parameter int CHUNK_W    = 12,
  parameter int MAX_SER    = BD_MAX_SER,
  parameter int NUM_LEAVES = BD_NUM_LEAVES,
  parameter logic [NUM_LEAVES*$clog2(MAX_SER+1)-1:0] SER_TABLE =
    (NUM_LEAVES*$clog2(MAX_SER+1))'(BD_SER_TABLE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN*LEAF_W-1:0]    in_leaf,
  input  logic [NUM_IN*PAYLOAD_W-1:0] in_payload,
  input  logic [NUM_IN-1:0]           in_v,
  output logic [NUM_IN-1:0]           in_a,
  output logic [LEAF_W-1:0]           out_leaf,
  output logic [CHUNK_W-1:0]          out_payload,
  output logic                        out_last,
  output logic                        out_v,
  input  logic                        out_a,
  output logic                        err_bad_leaf
);

  localparam int CNT_W = $clog2(MAX_SER + 1);
  localparam int EXT_W = MAX_SER * CHUNK_W;

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e             state_q, state_d;
  logic [LEAF_W-1:0]  leaf_q, leaf_d;
  logic [EXT_W-1:0]   pay_q, pay_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic               err_q, err_d;

  logic [NUM_IN-1:0]    gnt;
  logic                 last;
  logic                 take;
  logic                 adv;
  logic [LEAF_W-1:0]    sel_leaf;
  logic [PAYLOAD_W-1:0] sel_pay;
  logic [CNT_W-1:0]     ent;
  logic                 ok;

  // Holding reg may be refilled when empty or on the
  // last chunk's transfer; reset blocks any accept.
  assign last = (state_q == S_SEND) && (k_q == cnt_q - CNT_W'(1));
  assign take = reset && ((state_q == S_IDLE) || (out_a && last));
  assign adv  = take && (|in_v);
  assign in_a = adv ? gnt : '0;

  rr_arbiter #(
    .N(NUM_IN)
  ) u_arb (
    .clk   (clk),
    .rst_n (reset),
    .req_i (in_v),
    .adv_i (adv),
    .gnt_o (gnt)
  );

  // Select the granted channel's word.
  always_comb begin
    sel_leaf = '0;
    sel_pay  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) begin
        sel_leaf = in_leaf[i*LEAF_W +: LEAF_W];
        sel_pay  = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // Chunk count lookup; bad leaf or entry falls back to 1.
  always_comb begin
    ent = '0;
    for (int l = 0; l < NUM_LEAVES; l++) begin
      if (sel_leaf == LEAF_W'(l)) ent = SER_TABLE[l*CNT_W +: CNT_W];
    end
    ok = (int'(sel_leaf) < NUM_LEAVES) && cnt_ok(int'(ent), MAX_SER);
  end

  // FSM next state: step chunks, capture on take.
  always_comb begin
    state_d = state_q;
    leaf_d  = leaf_q;
    pay_d   = pay_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    err_d   = err_q;
    if ((state_q == S_SEND) && out_a && !last) begin
      k_d = k_q + CNT_W'(1);
    end
    if (take) begin
      if (|in_v) begin
        state_d = S_SEND;
        leaf_d  = sel_leaf;
        pay_d   = EXT_W'(sel_pay);
        cnt_d   = ok ? ent : CNT_W'(1);
        k_d     = '0;
        if (!ok) err_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State and holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      leaf_q  <= '0;
      pay_q   <= '0;
      cnt_q   <= CNT_W'(1);
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      leaf_q  <= leaf_d;
      pay_q   <= pay_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  assign out_v        = (state_q == S_SEND);
  assign out_leaf     = leaf_q;
  assign out_last     = last;
  assign out_payload  = CHUNK_W'(pay_q >> (int'(k_q) * CHUNK_W));
  assign err_bad_leaf = err_q;

endmodule

// File: tb/tb_bd_funnel_serializer_rr.sv
// Bench for bd_funnel_serializer_rr: scoreboard of
// expected chunks plus a round-robin grant model.
module tb_bd_funnel_serializer_rr;
  import bd_funnel_pkg::*;

  localparam int NI   = 4;
  localparam int LW   = 5;
  localparam int PW   = 25;
  localparam int CW   = 12;
  localparam int MS   = 4;
  localparam int NL   = 20;
  localparam int CNTW = 3;

  function automatic int tcnt(int l);
    if (l == 19) return 0;
    return ((l + 3) % 4) + 1;
  endfunction

  function automatic logic [NL*CNTW-1:0] mk_tbl();
    logic [NL*CNTW-1:0] t;
    t = '0;
    for (int l = 0; l < NL; l++) t[l*CNTW +: CNTW] = CNTW'(tcnt(l));
    return t;
  endfunction

  localparam logic [NL*CNTW-1:0] TBL = mk_tbl();

  logic             clk;
  logic             reset;
  logic [NI*LW-1:0] in_leaf;
  logic [NI*PW-1:0] in_payload;
  logic [NI-1:0]    in_v;
  logic [NI-1:0]    in_a;
  logic [LW-1:0]    out_leaf;
  logic [CW-1:0]    out_payload;
  logic             out_last;
  logic             out_v;
  logic             out_a;
  logic             err_bad_leaf;

  bd_funnel_serializer_rr #(
    .NUM_IN(NI), .LEAF_W(LW), .PAYLOAD_W(PW), .CHUNK_W(CW),
    .MAX_SER(MS), .NUM_LEAVES(NL), .SER_TABLE(TBL)
  ) dut (
    .clk(clk), .reset(reset),
    .in_leaf(in_leaf), .in_payload(in_payload),
    .in_v(in_v), .in_a(in_a),
    .out_leaf(out_leaf), .out_payload(out_payload),
    .out_last(out_last), .out_v(out_v), .out_a(out_a),
    .err_bad_leaf(err_bad_leaf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] leaf;
    logic [CW-1:0] chunk;
    logic          last;
  } exp_t;

  UnencodedBDWord chq[NI][$];
  exp_t           sb[$];
  exp_t           outlog[$];
  int             gseq[$];
  int             gcyc[$];

  int            checks;
  int            errors;
  int            cyc;
  int            rr_m;
  logic [NI-1:0] acc;
  bit            bp;
  bit            held;
  exp_t          hold_v;

  task automatic push_word(int ch, int leaf, logic [PW-1:0] pay);
    UnencodedBDWord w;
    w.leaf_code = LW'(leaf);
    w.payload   = pay;
    chq[ch].push_back(w);
  endtask

  task automatic expect_word(UnencodedBDWord w);
    int n;
    bit good;
    logic [MS*CW-1:0] ext;
    exp_t e;
    good = (int'(w.leaf_code) < NL) && (tcnt(int'(w.leaf_code)) >= 1)
           && (tcnt(int'(w.leaf_code)) <= MS);
    n    = good ? tcnt(int'(w.leaf_code)) : 1;
    ext  = {{(MS*CW-PW){1'b0}}, w.payload};
    for (int k = 0; k < n; k++) begin
      e.leaf  = w.leaf_code;
      e.chunk = ext[k*CW +: CW];
      e.last  = (k == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      if (acc[i] && chq[i].size() > 0) void'(chq[i].pop_front());
    end
    acc = '0;
    for (int i = 0; i < NI; i++) begin
      if (chq[i].size() > 0) begin
        in_v[i]              = 1'b1;
        in_leaf[i*LW +: LW]  = chq[i][0].leaf_code;
        in_payload[i*PW +: PW] = chq[i][0].payload;
      end else begin
        in_v[i]              = 1'b0;
        in_leaf[i*LW +: LW]  = '0;
        in_payload[i*PW +: PW] = '0;
      end
    end
    out_a = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic tick();
    exp_t cur;
    exp_t e;
    int g;
    int idx;
    logic [NI-1:0] expg;
    @(negedge clk);
    if (reset) begin
      cur.leaf  = out_leaf;
      cur.chunk = out_payload;
      cur.last  = out_last;
      if (held) begin
        checks++;
        if (out_v !== 1'b1 || cur.leaf !== hold_v.leaf ||
            cur.chunk !== hold_v.chunk || cur.last !== hold_v.last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b leaf=%0d chunk=%h last=%b want v=1 leaf=%0d chunk=%h last=%b",
                   out_v, cur.leaf, cur.chunk, cur.last,
                   hold_v.leaf, hold_v.chunk, hold_v.last);
        end
      end
      held   = (out_v === 1'b1) && (out_a === 1'b0);
      hold_v = cur;
      if (out_v === 1'b1 && out_a === 1'b1) begin
        checks++;
        outlog.push_back(cur);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_chunk: got leaf=%0d chunk=%h last=%b want none",
                   cur.leaf, cur.chunk, cur.last);
        end else begin
          e = sb.pop_front();
          if (cur.leaf !== e.leaf || cur.chunk !== e.chunk || cur.last !== e.last) begin
            errors++;
            $display("FAIL sb_chunk: got leaf=%0d chunk=%h last=%b want leaf=%0d chunk=%h last=%b",
                     cur.leaf, cur.chunk, cur.last, e.leaf, e.chunk, e.last);
          end
        end
      end
      if (in_a !== '0) begin
        g = -1;
        for (int off = 1; off <= NI; off++) begin
          idx = (rr_m + off) % NI;
          if (g < 0 && in_v[idx]) g = idx;
        end
        expg = (g < 0) ? '0 : NI'(1) << g;
        checks++;
        if (in_a !== expg) begin
          errors++;
          $display("FAIL grant: got in_a=%b want %b (in_v=%b)", in_a, expg, in_v);
        end
        for (int i = 0; i < NI; i++) begin
          if (in_a[i] === 1'b1 && in_v[i] === 1'b1) begin
            expect_word(chq[i][0]);
            rr_m = i;
            gseq.push_back(i);
            gcyc.push_back(cyc);
          end
        end
        acc = in_a & in_v;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit busy();
    for (int i = 0; i < NI; i++) if (chq[i].size() > 0) return 1'b1;
    return (sb.size() > 0) || (out_v === 1'b1);
  endfunction

  task automatic drain(int maxc);
    int n;
    n = 0;
    while (busy() && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles busy, want idle within %0d (sb=%0d)",
               n, maxc, sb.size());
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NI; i++) chq[i].delete();
    sb.delete();
    acc  = '0;
    held = 1'b0;
    rr_m = NI - 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bp    = 1'b0;
    clear_model();
    for (int i = 0; i < NI; i++) push_word(i, 1, PW'(32'h100 + i));
    drive();
    repeat (3) tick();
    checks++;
    if (in_a !== '0) begin
      errors++; $display("FAIL rst_in_a: got %b want 0", in_a);
    end
    checks++;
    if (out_v !== 1'b0) begin
      errors++; $display("FAIL rst_out_v: got %b want 0", out_v);
    end
    checks++;
    if (err_bad_leaf !== 1'b0) begin
      errors++; $display("FAIL rst_err: got %b want 0", err_bad_leaf);
    end
    checks++;
    if (out_last !== 1'b0 || out_payload !== '0 || out_leaf !== '0) begin
      errors++;
      $display("FAIL rst_fields: got last=%b pay=%h leaf=%0d want 0", out_last, out_payload, out_leaf);
    end
    gseq.delete();
    reset = 1'b1;
    drain(200);
    checks++;
    if (gseq.size() == 0 || gseq[0] != 0) begin
      errors++;
      $display("FAIL rst_first_grant: got %0d want 0", (gseq.size() == 0) ? -1 : gseq[0]);
    end
  endtask

  task automatic test_chunks();
    outlog.delete();
    push_word(0, 3, 25'h1ABCDEF);
    drive();
    drain(200);
    checks++;
    if (outlog.size() != 3) begin
      errors++;
      $display("FAIL chunk_count: got %0d want 3", outlog.size());
    end else begin
      checks++;
      if (outlog[0].chunk !== 12'hDEF || outlog[0].last !== 1'b0) begin
        errors++; $display("FAIL chunk0: got %h/%b want def/0", outlog[0].chunk, outlog[0].last);
      end
      checks++;
      if (outlog[1].chunk !== 12'hABC || outlog[1].last !== 1'b0) begin
        errors++; $display("FAIL chunk1: got %h/%b want abc/0", outlog[1].chunk, outlog[1].last);
      end
      checks++;
      if (outlog[2].chunk !== 12'h001 || outlog[2].last !== 1'b1 || outlog[2].leaf !== 5'd3) begin
        errors++;
        $display("FAIL chunk2: got %h/%b leaf %0d want 001/1 leaf 3",
                 outlog[2].chunk, outlog[2].last, outlog[2].leaf);
      end
    end
  endtask

  task automatic test_back_to_back();
    int start;
    int bad_ord;
    int bubbles;
    start = rr_m;
    gseq.delete();
    gcyc.delete();
    for (int w = 0; w < 4; w++) begin
      for (int ch = 0; ch < NI; ch++) push_word(ch, 1, PW'((ch << 8) | w));
    end
    drive();
    drain(300);
    bad_ord = 0;
    bubbles = 0;
    for (int j = 0; j < gseq.size(); j++) begin
      if (gseq[j] != (start + 1 + j) % NI) bad_ord++;
      if (j > 0 && gcyc[j] != gcyc[j-1] + 1) bubbles++;
    end
    checks++;
    if (gseq.size() != 16) begin
      errors++; $display("FAIL b2b_words: got %0d want 16", gseq.size());
    end
    checks++;
    if (bad_ord != 0) begin
      errors++; $display("FAIL b2b_order: got %0d misordered grants want 0", bad_ord);
    end
    checks++;
    if (bubbles != 0) begin
      errors++; $display("FAIL b2b_bubbles: got %0d want 0", bubbles);
    end
  endtask

  task automatic test_backpressure();
    bp = 1'b1;
    for (int w = 0; w < 40; w++) begin
      push_word($urandom_range(0, NI - 1), $urandom_range(0, 18),
                PW'($urandom()));
    end
    drive();
    drain(3000);
    bp = 1'b0;
    drive();
  endtask

  task automatic test_bad_leaf();
    checks++;
    if (err_bad_leaf !== 1'b0) begin
      errors++; $display("FAIL err_before_bad: got %b want 0", err_bad_leaf);
    end
    outlog.delete();
    push_word(2, NL, 25'h0ABC123);
    drive();
    drain(200);
    checks++;
    if (outlog.size() != 1 || outlog[0].chunk !== 12'h123 || outlog[0].last !== 1'b1) begin
      errors++;
      $display("FAIL bad_leaf_chunks: got %0d chunks want 1 chunk 123 last", outlog.size());
    end
    checks++;
    if (err_bad_leaf !== 1'b1) begin
      errors++; $display("FAIL bad_leaf_err: got %b want 1", err_bad_leaf);
    end
    push_word(0, 1, 25'h55);
    drive();
    drain(200);
    checks++;
    if (err_bad_leaf !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err_bad_leaf);
    end
  endtask

  task automatic test_bad_entry();
    reset = 1'b0;
    clear_model();
    drive();
    repeat (2) tick();
    checks++;
    if (err_bad_leaf !== 1'b0) begin
      errors++; $display("FAIL err_cleared: got %b want 0", err_bad_leaf);
    end
    reset = 1'b1;
    outlog.delete();
    push_word(1, 19, 25'h1FFF456);
    drive();
    drain(200);
    checks++;
    if (outlog.size() != 1 || err_bad_leaf !== 1'b1) begin
      errors++;
      $display("FAIL bad_entry: got %0d chunks err=%b want 1 chunk err=1",
               outlog.size(), err_bad_leaf);
    end
  endtask

  task automatic test_reset_mid_word();
    int n;
    int stray;
    outlog.delete();
    push_word(0, 0, 25'h1234567);
    drive();
    n = 0;
    while (outlog.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_v !== 1'b0 || in_a !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: got out_v=%b in_a=%b want 0/0", out_v, in_a);
    end
    clear_model();
    drive();
    repeat (2) tick();
    reset = 1'b1;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_v !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL leftover_chunks: got %0d cycles out_v want 0", stray);
    end
    push_word(3, 2, 25'h0F0F0F0);
    drive();
    drain(200);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    reset      = 1'b0;
    in_v       = '0;
    in_leaf    = '0;
    in_payload = '0;
    out_a      = 1'b1;
    bp         = 1'b0;
    acc        = '0;
    held       = 1'b0;
    rr_m       = NI - 1;
    #2;
    test_reset();
    test_chunks();
    test_back_to_back();
    test_backpressure();
    test_bad_leaf();
    test_bad_entry();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
